vga_sync_gen: RTL and testbench

//  Consumes the free-running h/v pixel counters from the VGA pixel counter stage and produces

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_delay_line.sv | 31 +++
 rtl/vga_sync_gen.sv | 147 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the per-pixel sync bundle that
// travels down the output pipeline.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       line_start;
        logic       frame_start;
    } vga_sync_t;

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset register chain; every stage flushes to RESET_VAL so a partly
// filled pipeline never shows stale timing.
module vga_delay_line #(
    parameter int  DEPTH     = 1,
    parameter type T         = logic,
    parameter T    RESET_VAL = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  T     d,
    output T     q
);

    T stages [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RESET_VAL;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// Turns free-running h/v pixel counters into registered VGA timing, counts
// frames and flags any break in the counter sequence with a sticky error.
module vga_sync_gen
    import vga_timing_pkg::vga_sync_t;
#(
    parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP        = vga_timing_pkg::H_FP,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BP        = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP        = vga_timing_pkg::V_FP,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BP        = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL    = 1'b0,
    parameter int PIPE_STAGES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       err_clr,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       timing_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Extended by one bit so out-of-range counters compare without wrapping.
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] H_TOT    = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
    localparam logic [9:0]  H_END    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_END    = 10'(V_TOTAL - 1);

    localparam vga_sync_t IDLE = '{hsync: !SYNC_POL, vsync: !SYNC_POL, de: 1'b0,
                                   x: '0, y: '0, line_start: 1'b0, frame_start: 1'b0};

    logic [10:0] h_ext;
    logic [10:0] v_ext;
    vga_sync_t   decoded;
    vga_sync_t   stage1;
    vga_sync_t   out_bundle;
    logic [9:0]  prev_h;
    logic [9:0]  prev_v;
    logic        seq_valid;
    logic        seq_ok;
    logic        err_det;

    assign h_ext = {1'b0, h_counter};
    assign v_ext = {1'b0, v_counter};

    always_comb begin
        decoded             = IDLE;
        decoded.hsync       = (h_ext >= HS_FIRST && h_ext <= HS_LAST) ? SYNC_POL : !SYNC_POL;
        decoded.vsync       = (v_ext >= VS_FIRST && v_ext <= VS_LAST) ? SYNC_POL : !SYNC_POL;
        decoded.de          = (h_ext < H_ACT) && (v_ext < V_ACT);
        decoded.x           = decoded.de ? h_counter : '0;
        decoded.y           = decoded.de ? v_counter : '0;
        decoded.line_start  = (h_counter == '0);
        decoded.frame_start = (h_counter == '0) && (v_counter == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage1 <= IDLE;
        end else begin
            stage1 <= decoded;
        end
    end

    generate
        if (PIPE_STAGES > 1) begin : g_delay
            vga_delay_line #(
                .DEPTH     (PIPE_STAGES - 1),
                .T         (vga_sync_t),
                .RESET_VAL (IDLE)
            ) u_delay (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (stage1),
                .q       (out_bundle)
            );
        end else begin : g_bypass
            assign out_bundle = stage1;
        end
    endgenerate

    assign hsync       = out_bundle.hsync;
    assign vsync       = out_bundle.vsync;
    assign de          = out_bundle.de;
    assign x_pixel     = out_bundle.x;
    assign y_pixel     = out_bundle.y;
    assign line_start  = out_bundle.line_start;
    assign frame_start = out_bundle.frame_start;

    // Counts the frame_start pulse already visible at the output, so it stays aligned with any depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (out_bundle.frame_start) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    always_comb begin
        if (prev_h == H_END) begin
            seq_ok = (h_counter == '0) &&
                     (v_ext == ((prev_v == V_END) ? 11'd0 : {1'b0, prev_v} + 11'd1));
        end else begin
            seq_ok = (h_ext == {1'b0, prev_h} + 11'd1) && (v_counter == prev_v);
        end
        err_det = (seq_valid && !seq_ok) || (h_ext >= H_TOT) || (v_ext >= V_TOT);
    end

    // A fresh error outranks err_clr in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_h     <= '0;
            prev_v     <= '0;
            seq_valid  <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            prev_h    <= h_counter;
            prev_v    <= v_counter;
            seq_valid <= 1'b1;
            if (err_det) begin
                timing_err <= 1'b1;
            end else if (err_clr) begin
                timing_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: one-stage and four-stage instances share stimulus and
// are compared every cycle against a timing model built from pixel positions.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    localparam bit POL = 1'b0;

    typedef struct {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } exp_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] h_counter = '0;
    logic [9:0] v_counter = '0;
    logic       err_clr   = 1'b0;

    logic [1:0]       hs, vs, de_o, ls, fs, te;
    logic [1:0][9:0]  xp, yp;
    logic [1:0][7:0]  fc;

    int checks = 0;
    int errors = 0;

    int   cap_h[$];
    int   cap_v[$];
    int   n_caps = 0;
    int   fcnt_m[2] = '{0, 0};
    logic terr_m = 1'b0;
    int   prev_h = 0;
    int   prev_v = 0;
    bit   prev_valid = 1'b0;

    int hs_cnt[2], vs_cnt[2], de_cnt[2];

    always #5 clk = ~clk;

    vga_sync_gen #(.PIPE_STAGES(1)) dut_p1 (
        .clk(clk), .reset_n(reset_n), .h_counter(h_counter), .v_counter(v_counter),
        .err_clr(err_clr), .hsync(hs[0]), .vsync(vs[0]), .de(de_o[0]),
        .x_pixel(xp[0]), .y_pixel(yp[0]), .line_start(ls[0]), .frame_start(fs[0]),
        .frame_count(fc[0]), .timing_err(te[0])
    );

    vga_sync_gen #(.PIPE_STAGES(4)) dut_p4 (
        .clk(clk), .reset_n(reset_n), .h_counter(h_counter), .v_counter(v_counter),
        .err_clr(err_clr), .hsync(hs[1]), .vsync(vs[1]), .de(de_o[1]),
        .x_pixel(xp[1]), .y_pixel(yp[1]), .line_start(ls[1]), .frame_start(fs[1]),
        .frame_count(fc[1]), .timing_err(te[1])
    );

    function automatic int pipe_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Output of a p-deep pipeline is the pixel captured p edges ago, or idle if not yet filled.
    function automatic exp_t expect_out(input int p);
        exp_t e;
        int   h, v;
        e.hs = !POL; e.vs = !POL; e.de = 1'b0; e.x = '0; e.y = '0; e.ls = 1'b0; e.fs = 1'b0;
        if (n_caps >= p) begin
            h = cap_h[cap_h.size() - p];
            v = cap_v[cap_v.size() - p];
            e.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? POL : !POL;
            e.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? POL : !POL;
            e.de = (h < H_ACTIVE) && (v < V_ACTIVE);
            e.x  = e.de ? 10'(h) : 10'd0;
            e.y  = e.de ? 10'(v) : 10'd0;
            e.ls = (h == 0);
            e.fs = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        cap_h.delete();
        cap_v.delete();
        n_caps     = 0;
        fcnt_m     = '{0, 0};
        terr_m     = 1'b0;
        prev_valid = 1'b0;
    endtask

    task automatic model_edge(input int h, input int v, input bit clr);
        exp_t e;
        int   eh, ev;
        logic err_now;
        for (int k = 0; k < 2; k++) begin
            e = expect_out(pipe_of(k));
            if (e.fs) fcnt_m[k] = (fcnt_m[k] + 1) % 256;
        end
        if (prev_h == H_TOTAL - 1) begin
            eh = 0;
            ev = (prev_v == V_TOTAL - 1) ? 0 : prev_v + 1;
        end else begin
            eh = prev_h + 1;
            ev = prev_v;
        end
        err_now = (h >= H_TOTAL) || (v >= V_TOTAL) || (prev_valid && (h != eh || v != ev));
        if (err_now) terr_m = 1'b1;
        else if (clr) terr_m = 1'b0;
        prev_h = h;
        prev_v = v;
        prev_valid = 1'b1;
        cap_h.push_back(h);
        cap_v.push_back(v);
        if (cap_h.size() > 4) begin
            void'(cap_h.pop_front());
            void'(cap_v.pop_front());
        end
        n_caps++;
    endtask

    task automatic checkOutput();
        exp_t e;
        int   p;
        for (int k = 0; k < 2; k++) begin
            p = pipe_of(k);
            e = expect_out(p);
            chk($sformatf("p%0d_hsync", p), hs[k], e.hs);
            chk($sformatf("p%0d_vsync", p), vs[k], e.vs);
            chk($sformatf("p%0d_de", p), de_o[k], e.de);
            chk($sformatf("p%0d_x", p), xp[k], e.x);
            chk($sformatf("p%0d_y", p), yp[k], e.y);
            chk($sformatf("p%0d_line_start", p), ls[k], e.ls);
            chk($sformatf("p%0d_frame_start", p), fs[k], e.fs);
            chk($sformatf("p%0d_frame_count", p), fc[k], fcnt_m[k]);
            chk($sformatf("p%0d_timing_err", p), te[k], terr_m);
        end
    endtask

    // Checks the outputs, then presents one new pixel that the next rising edge captures.
    task automatic applyStimulus(input int h, input int v, input bit clr);
        @(negedge clk);
        checkOutput();
        reset_n   = 1'b1;
        h_counter = 10'(h);
        v_counter = 10'(v);
        err_clr   = clr;
        model_edge(int'(h_counter), int'(v_counter), clr);
        @(posedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checkOutput();
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_tally();
        hs_cnt = '{0, 0}; vs_cnt = '{0, 0}; de_cnt = '{0, 0};
    endtask

    task automatic tally();
        #1;
        for (int k = 0; k < 2; k++) begin
            if (hs[k] === POL)  hs_cnt[k]++;
            if (vs[k] === POL)  vs_cnt[k]++;
            if (de_o[k] === 1'b1) de_cnt[k]++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int on_h[2], off_h[2], fs_h[2];
        int h, v;

        $display("[TB] start");
        repeat (3) @(negedge clk);
        #1;
        checkOutput();

        // Full lines from the frame origin; line 1 is tallied end to end.
        for (int vv = 0; vv < 3; vv++) begin
            if (vv == 1) clear_tally();
            for (int hh = 0; hh < H_TOTAL; hh++) begin
                applyStimulus(hh, vv, 1'b0);
                if (vv == 1) tally();
            end
            if (vv == 1) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("p%0d_line_hsync_cycles", pipe_of(k)), hs_cnt[k], 96);
                    chk($sformatf("p%0d_line_de_cycles", pipe_of(k)), de_cnt[k], 640);
                end
            end
        end

        // Lines 488..493 cover the vertical sync pulse.
        clear_tally();
        for (int vv = 487; vv <= 493; vv++) begin
            for (int hh = 0; hh < H_TOTAL; hh++) begin
                applyStimulus(hh, vv, 1'b0);
                if (vv >= 488) tally();
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p%0d_vsync_cycles", pipe_of(k)), vs_cnt[k], 1600);
            chk($sformatf("p%0d_vblank_hsync_cycles", pipe_of(k)), hs_cnt[k], 576);
            chk($sformatf("p%0d_vblank_de_cycles", pipe_of(k)), de_cnt[k], 0);
        end

        on_h = '{-1, -1};
        off_h = '{-1, -1};
        for (int hh = 600; hh <= 780; hh++) begin
            applyStimulus(hh, 10, 1'b0);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (hs[k] === POL && on_h[k] < 0) on_h[k] = hh;
                if (on_h[k] >= 0 && off_h[k] < 0 && hs[k] === !POL) off_h[k] = hh;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p%0d_hsync_on_edge", pipe_of(k)), on_h[k], 656 + pipe_of(k) - 1);
            chk($sformatf("p%0d_hsync_off_edge", pipe_of(k)), off_h[k], 752 + pipe_of(k) - 1);
        end

        // Frame boundary and frame_count wrap after 256 frames.
        applyReset();
        applyStimulus(798, 524, 1'b0);
        applyStimulus(799, 524, 1'b0);
        applyStimulus(0, 0, 1'b0);
        #1;
        chk("p1_frame_start_pulse", fs[0], 1'b1);
        chk("p1_line_start_pulse", ls[0], 1'b1);
        chk("p1_count_before_inc", fc[0], 8'd0);
        chk("p4_frame_start_early", fs[1], 1'b0);
        applyStimulus(1, 0, 1'b0);
        #1;
        chk("p1_count_after_inc", fc[0], 8'd1);
        chk("p1_frame_start_one_cycle", fs[0], 1'b0);
        applyStimulus(2, 0, 1'b0);
        applyStimulus(3, 0, 1'b0);
        #1;
        chk("p4_frame_start_pulse", fs[1], 1'b1);
        chk("p4_count_before_inc", fc[1], 8'd0);
        applyStimulus(4, 0, 1'b0);
        #1;
        chk("p4_count_after_inc", fc[1], 8'd1);
        for (int f = 0; f < 254; f++) begin
            applyStimulus(799, 524, 1'b0);
            for (int hh = 0; hh <= 4; hh++) applyStimulus(hh, 0, 1'b0);
        end
        applyStimulus(5, 0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("p%0d_count_255", pipe_of(k)), fc[k], 8'd255);
        applyStimulus(799, 524, 1'b0);
        for (int hh = 0; hh <= 5; hh++) applyStimulus(hh, 0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("p%0d_count_wrap", pipe_of(k)), fc[k], 8'd0);

        // Sticky error: skip, hold, clear, and clear losing to a same-cycle error.
        applyStimulus(90, 20, 1'b0);
        applyStimulus(91, 20, 1'b1);
        for (int hh = 92; hh <= 100; hh++) applyStimulus(hh, 20, 1'b0);
        #1;
        chk("err_clean_before_jump", te[0], 1'b0);
        applyStimulus(102, 20, 1'b0);
        #1;
        chk("err_set_after_jump", te[0], 1'b1);
        for (int hh = 103; hh <= 110; hh++) applyStimulus(hh, 20, 1'b0);
        #1;
        chk("err_sticky", te[1], 1'b1);
        applyStimulus(111, 20, 1'b1);
        #1;
        chk("err_cleared", te[0], 1'b0);
        applyStimulus(820, 20, 1'b1);
        #1;
        chk("err_beats_clear", te[0], 1'b1);

        // Asynchronous reset mid-line, then restart at the frame origin.
        for (int hh = 290; hh <= 300; hh++) applyStimulus(hh, 200, 1'b0);
        applyReset();
        fs_h = '{-1, -1};
        for (int hh = 0; hh <= 10; hh++) begin
            applyStimulus(hh, 0, 1'b0);
            #1;
            for (int k = 0; k < 2; k++) if (fs[k] === 1'b1 && fs_h[k] < 0) fs_h[k] = hh;
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("p%0d_post_reset_frame_start", pipe_of(k)), fs_h[k], pipe_of(k) - 1);
            chk($sformatf("p%0d_post_reset_no_err", pipe_of(k)), te[k], 1'b0);
        end

        // Random run near the frame wrap with occasional glitches, clears and one reset.
        h = $urandom_range(0, H_TOTAL - 1);
        v = $urandom_range(V_TOTAL - 5, V_TOTAL - 1);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) applyReset();
            if ($urandom_range(0, 63) == 0) begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 600);
            end
            applyStimulus(h, v, ($urandom_range(0, 15) == 0));
            if (h >= H_TOTAL - 1) begin
                h = 0;
                v = (v >= V_TOTAL - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
        end
        applyStimulus(h, v, 1'b0);
        @(negedge clk);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
